execute_unit: RTL and testbench
===============================

EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 Parameter WIDTH, default 16, datapath/operand/result width in bits (≥8, power of two).
REQ-002 Parameter RADDR, default 4, destination register index width.
REQ-003 Parameter MUL_EN, default 1: 1 = multi-cycle MUL implemented; 0 = MUL treated as ADD.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  upstream presents an operation this cycle.
REQ-007 in_ready  out  1  unit accepts operation this cycle; accept = in_valid && in_ready.
REQ-008 pc, a, b, imm, fwd  in  WIDTH each  operand sources; fwd = forwarded result from later stage.
REQ-009 rd  in  RADDR  destination register index.
REQ-010 aluop  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL.
REQ-011 aluin1  in  2  operand-1 select: 0 pc, 1 a, 2 fwd, 3 zero.
REQ-012 aluin2  in  2  operand-2 select: 0 b, 1 constant 2, 2 imm, 3 fwd.
REQ-013 out_valid  out  1  result register holds valid result.
REQ-014 out_ready  in  1  downstream consumes result; consume = out_valid && out_ready.
REQ-015 aluout  out  WIDTH  registered result.
REQ-016 bout  out  WIDTH  registered copy of b captured at accept.
REQ-017 rdout  out  RADDR  registered copy of rd captured at accept.
REQ-018 zero, pos  out  1 each  registered flags of aluout.
REQ-019 busy  out  1  high while a MUL is in progress or waiting to retire.

Function
REQ-020 Operands sampled only at accept; operand selects and aluop ignored otherwise.
REQ-021 Arithmetic modulo 2^WIDTH; carries/overflow discarded; SUB = in1 - in2.
REQ-022 SLL/SRL: shift in1 by in2[log2(WIDTH)-1:0], logical, zero fill.
REQ-023 MUL: low WIDTH bits of in1*in2 (unsigned), computed by iterative shift-add, one bit per cycle.
REQ-024 States: IDLE, MUL, DONE; reset state IDLE.
REQ-025 in_ready = !rst && state==IDLE && (!out_valid || out_ready).
REQ-026 Single-cycle op accepted in cycle N: aluout/bout/rdout/flags loaded and out_valid=1 at edge ending N (visible cycle N+1).
REQ-027 MUL accepted in cycle N: IDLE->MUL, iteration counter runs WIDTH cycles; MUL->DONE after last iteration.
REQ-028 DONE: result loaded and out_valid set on the first edge where (!out_valid || out_ready); then ->IDLE; earliest visible cycle N+WIDTH+1.
REQ-029 out_valid && !out_ready: aluout, bout, rdout, zero, pos, out_valid held stable.
REQ-030 Consume with no new load clears out_valid next edge; consume with simultaneous load keeps out_valid=1 with new data (back-to-back, no bubble).
REQ-031 zero = (result==0); pos = (result MSB==0) && !zero; computed from value loaded into aluout.
REQ-032 busy = state!=IDLE.
REQ-033 MUL_EN=0: aluop 7 behaves as ADD, single-cycle; MUL/DONE unreachable.

Reset
REQ-034 rst high at an edge: state IDLE, counter 0, out_valid 0, aluout/bout/rdout 0, zero 1, pos 0, busy 0.
REQ-035 rst during MUL or DONE aborts the operation; no result is ever emitted for it.
REQ-036 in_ready is 0 in any cycle rst is high; operations presented then are dropped.

Verification (WIDTH=16, RADDR=4)
REQ-037 aluop=0, aluin1=1 a=0x0005, aluin2=2 imm=0x0003, rd=7, out_ready=1 -> next cycle out_valid=1, aluout=0x0008, rdout=7, zero=0, pos=1.
REQ-038 aluop=1, aluin1=3, aluin2=1 -> aluout=0xFFFE, zero=0, pos=0; aluop=1, aluin1=1 a=2, aluin2=1 -> aluout=0, zero=1.
REQ-039 aluop=7 a=0x0123 b=0x0010 (sel 1/0) accepted cycle N, out_ready=1 -> busy cycles N+1..N+16, in_ready=0 there, out_valid first in N+17 with aluout=0x1230.
REQ-040 Two ADDs back-to-back with out_ready=0 on second -> first result held stable, in_ready=0; raising out_ready retires first, loads second same edge, out_valid stays 1.
REQ-041 rst asserted mid-MUL (cycle N+5) -> next cycle all outputs at reset values, no out_valid for that MUL; new ADD accepted after rst drops completes normally.
REQ-042 aluop=5 a=0x0001 b=0x0013, and aluop=6 a=0x8000 b=0x000F -> aluout=0x0008 and 0x0001 (shift amount uses low 4 bits).

Source files
------------

// File: rtl/execute_unit.sv
`default_nettype none
// ============================================================================
// Module      : execute_unit
// Description : Pipeline execute stage with single-cycle ALU ops and an
//               iterative shift-add multiplier behind a valid/ready result.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_unit #(
    parameter int WIDTH  = 16,
    parameter int RADDR  = 4,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] fwd,
    input  logic [RADDR-1:0] rd,
    input  logic [2:0]       aluop,
    input  logic [1:0]       aluin1,
    input  logic [1:0]       aluin2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluout,
    output logic [WIDTH-1:0] bout,
    output logic [RADDR-1:0] rdout,
    output logic             zero,
    output logic             pos,
    output logic             busy
);

    localparam int             c_SHW  = $clog2(WIDTH);
    localparam logic [c_SHW-1:0] c_LAST = c_SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_SHW-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_b_pend;
    logic [RADDR-1:0]   r_rd_pend;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_aluout;
    logic [WIDTH-1:0]   r_bout;
    logic [RADDR-1:0]   r_rdout;
    logic               r_zero;
    logic               r_pos;

    logic [WIDTH-1:0]   w_in1;
    logic [WIDTH-1:0]   w_in2;
    logic [WIDTH-1:0]   w_alu;
    logic               w_is_mul;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_out_free;
    logic               w_load_alu;
    logic               w_load_mul;
    logic               w_load;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_res_b;
    logic [RADDR-1:0]   w_res_rd;

    always_comb begin
        w_in1 = '0;
        case (aluin1)
            2'd0:    w_in1 = pc;
            2'd1:    w_in1 = a;
            2'd2:    w_in1 = fwd;
            default: w_in1 = '0;
        endcase
        w_in2 = '0;
        case (aluin2)
            2'd0:    w_in2 = b;
            2'd1:    w_in2 = WIDTH'(2);
            2'd2:    w_in2 = imm;
            default: w_in2 = fwd;
        endcase
    end

    // aluop 7 falls through to ADD here; the multiplier path handles it when enabled
    always_comb begin
        w_alu = w_in1 + w_in2;
        case (aluop)
            3'd1:    w_alu = w_in1 - w_in2;
            3'd2:    w_alu = w_in1 & w_in2;
            3'd3:    w_alu = w_in1 | w_in2;
            3'd4:    w_alu = w_in1 ^ w_in2;
            3'd5:    w_alu = w_in1 << w_in2[c_SHW-1:0];
            3'd6:    w_alu = w_in1 >> w_in2[c_SHW-1:0];
            default: w_alu = w_in1 + w_in2;
        endcase
    end

    assign w_is_mul   = (MUL_EN != 0) && (aluop == 3'd7);
    assign w_out_free = !r_out_valid || out_ready;
    assign w_in_ready = !rst && (r_state == S_IDLE) && w_out_free;
    assign w_accept   = in_valid && w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load_alu  = 1'b0;
        w_load_mul  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul)
                    w_state_nxt = S_MUL;
                else
                    w_load_alu = w_accept;
            end
            S_MUL: begin
                if (r_cnt == c_LAST)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_out_free) begin
                    w_load_mul  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_load   = w_load_alu || w_load_mul;
    assign w_res    = w_load_mul ? r_acc     : w_alu;
    assign w_res_b  = w_load_mul ? r_b_pend  : b;
    assign w_res_rd = w_load_mul ? r_rd_pend : rd;

    // Bit 0 of the multiplier is consumed on the accept edge, so the MUL state
    // needs WIDTH-1 further cycles and the result can retire WIDTH+1 cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_b_pend    <= '0;
            r_rd_pend   <= '0;
            r_out_valid <= 1'b0;
            r_aluout    <= '0;
            r_bout      <= '0;
            r_rdout     <= '0;
            r_zero      <= 1'b1;
            r_pos       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && w_is_mul) begin
                r_acc     <= w_in2[0] ? w_in1 : '0;
                r_mcand   <= w_in1 << 1;
                r_mplier  <= w_in2 >> 1;
                r_b_pend  <= b;
                r_rd_pend <= rd;
                r_cnt     <= c_SHW'(1);
            end else if (r_state == S_MUL) begin
                if (r_mplier[0])
                    r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + c_SHW'(1);
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_aluout    <= w_res;
                r_bout      <= w_res_b;
                r_rdout     <= w_res_rd;
                r_zero      <= (w_res == '0);
                r_pos       <= !w_res[WIDTH-1] && (w_res != '0);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign aluout    = r_aluout;
    assign bout      = r_bout;
    assign rdout     = r_rdout;
    assign zero      = r_zero;
    assign pos       = r_pos;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_execute_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_unit
// Description : Directed scoreboard bench for execute_unit (WIDTH=16, RADDR=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_unit;

    localparam logic [15:0] c_PC  = 16'h0100;
    localparam logic [15:0] c_FWD = 16'h0002;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] pc, a, b, imm, fwd;
    logic [3:0]  rd;
    logic [2:0]  aluop;
    logic [1:0]  aluin1, aluin2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] aluout, bout;
    logic [3:0]  rdout;
    logic        zero, pos, busy;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] bv;
        logic [3:0]  rdv;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    execute_unit #(.WIDTH(16), .RADDR(4), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .a(a), .b(b), .imm(imm), .fwd(fwd), .rd(rd),
        .aluop(aluop), .aluin1(aluin1), .aluin2(aluin2),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluout(aluout), .bout(bout), .rdout(rdout),
        .zero(zero), .pos(pos), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [2:0] op, input logic [1:0] s1,
                                          input logic [1:0] s2, input logic [15:0] av,
                                          input logic [15:0] bv, input logic [15:0] iv);
        logic [15:0] x, y;
        logic [31:0] p;
        x = (s1 == 2'd0) ? c_PC : (s1 == 2'd1) ? av : (s1 == 2'd2) ? c_FWD : 16'd0;
        y = (s2 == 2'd0) ? bv : (s2 == 2'd1) ? 16'd2 : (s2 == 2'd2) ? iv : c_FWD;
        p = {16'd0, x} * {16'd0, y};
        case (op)
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return x & y;
            3'd3: return x | y;
            3'd4: return x ^ y;
            3'd5: return x << y[3:0];
            3'd6: return x >> y[3:0];
            default: return p[15:0];
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            check({tag, "_aluout"}, {16'd0, aluout}, {16'd0, e.res});
            check({tag, "_bout"}, {16'd0, bout}, {16'd0, e.bv});
            check({tag, "_rdout"}, {28'd0, rdout}, {28'd0, e.rdv});
            check({tag, "_zero"}, {31'd0, zero}, {31'd0, (e.res == 16'd0)});
            check({tag, "_pos"}, {31'd0, pos}, {31'd0, (!e.res[15] && e.res != 16'd0)});
        end
    endtask

    // Present one op, wait for accept, record the expected result; returns in cycle N+1.
    task automatic send(input logic [2:0] op, input logic [1:0] s1, input logic [1:0] s2,
                        input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] iv, input logic [3:0] rv);
        bit ok;
        exp_t e;
        ok = 0;
        aluop = op; aluin1 = s1; aluin2 = s2; a = av; b = bv; imm = iv; rd = rv;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (in_ready) begin
                e.res = model(op, s1, s2, av, bv, iv);
                e.bv  = bv;
                e.rdv = rv;
                q.push_back(e);
                ok = 1;
            end
            step();
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    // Wait for the next result with out_ready high, compare it, let it retire.
    task automatic recv(input string tag, input int budget);
        bit got;
        got = 0;
        out_ready = 1'b1;
        for (int i = 0; i < budget && !got; i++) begin
            if (out_valid) begin
                compare_head(tag);
                got = 1;
            end
            step();
        end
        if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        pc = c_PC; fwd = c_FWD; a = 16'h1111; b = 16'h2222; imm = 16'h3333;
        rd = 4'd9; aluop = 3'd0; aluin1 = 2'd1; aluin2 = 2'd0;
        step();
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_aluout", {16'd0, aluout}, 32'd0);
        check("rst_bout", {16'd0, bout}, 32'd0);
        check("rst_rdout", {28'd0, rdout}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_pos", {31'd0, pos}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        check("post_rst_no_valid", {31'd0, out_valid}, 32'd0);

        send(3'd0, 2'd1, 2'd2, 16'h0005, 16'h0000, 16'h0003, 4'd7);
        recv("add_imm", 4);
        send(3'd1, 2'd3, 2'd1, 16'h0000, 16'h0000, 16'h0000, 4'd1);
        recv("sub_neg", 4);
        send(3'd1, 2'd1, 2'd1, 16'h0002, 16'h0000, 16'h0000, 4'd2);
        recv("sub_zero", 4);
        send(3'd5, 2'd1, 2'd0, 16'h0001, 16'h0013, 16'h0000, 4'd3);
        recv("sll", 4);
        send(3'd6, 2'd1, 2'd0, 16'h8000, 16'h000F, 16'h0000, 4'd4);
        recv("srl", 4);
        send(3'd2, 2'd0, 2'd2, 16'h0000, 16'h0000, 16'h0F00, 4'd5);
        recv("and_pc", 4);
        send(3'd3, 2'd2, 2'd0, 16'h0000, 16'hA000, 16'h0000, 4'd6);
        recv("or_fwd", 4);
        send(3'd4, 2'd1, 2'd3, 16'h00FF, 16'h0000, 16'h0000, 4'd8);
        recv("xor_fwd", 4);

        // MUL: busy and stalled for WIDTH cycles, result visible at N+17
        send(3'd7, 2'd1, 2'd0, 16'h0123, 16'h0010, 16'h0000, 4'd10);
        for (int i = 0; i < 16; i++) begin
            check("mul_busy", {31'd0, busy}, 32'd1);
            check("mul_in_ready", {31'd0, in_ready}, 32'd0);
            check("mul_early_valid", {31'd0, out_valid}, 32'd0);
            step();
        end
        check("mul_busy_end", {31'd0, busy}, 32'd0);
        recv("mul", 1);

        // Back-pressure: first result held, second loads on the retire edge
        send(3'd0, 2'd1, 2'd0, 16'h0010, 16'h0020, 16'h0000, 4'd11);
        out_ready = 1'b0;
        aluop = 3'd1; aluin1 = 2'd1; aluin2 = 2'd2; a = 16'h0050; b = 16'h0007;
        imm = 16'h0060; rd = 4'd12; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold", {16'd0, aluout}, 32'h0030);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        compare_head("bp_first");
        q.push_back('{res: 16'hFFF0, bv: 16'h0007, rdv: 4'd12});
        step();
        in_valid = 1'b0;
        compare_head("bp_second");
        step();
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a MUL aborts it
        send(3'd7, 2'd1, 2'd0, 16'h0003, 16'h0005, 16'h0000, 4'd13);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        void'(q.pop_back());
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_aluout", {16'd0, aluout}, 32'd0);
        check("abort_zero", {31'd0, zero}, 32'd1);
        check("abort_rdout", {28'd0, rdout}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            check("abort_no_valid", {31'd0, out_valid}, 32'd0);
            step();
        end
        send(3'd0, 2'd1, 2'd2, 16'h1234, 16'h0001, 16'h0001, 4'd14);
        recv("after_abort", 4);

        for (int k = 0; k < 10; k++) begin
            send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                 16'($urandom), 4'($urandom));
            recv("rand", 40);
        end
        check("sb_empty_end", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
